// File: rtl/mem_access_unit_pkg.sv
// Shared CPU definitions used by the memory access stage.
package mem_access_unit_pkg;

  localparam int unsigned WORD_W = 32;
  localparam logic [WORD_W-1:0] ERR_RDATA_DEFAULT = 32'h0000_0000;

  // ALU memory command encodings
  typedef enum logic [1:0] {
    MEMIO_NONE    = 2'b00,
    MEMIO_READ    = 2'b01,
    MEMIO_WRITE   = 2'b10,
    MEMIO_ILLEGAL = 2'b11
  } memio_t;

  // Memory access stage states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_REQ     = 2'b01,
    ST_DONE    = 2'b10,
    ST_RELEASE = 2'b11
  } state_t;

endpackage

// File: rtl/mem_req_timer.sv
// Bus-request wait timer: counts REQ cycles and flags the last allowed one.
module mem_req_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned TW = $clog2(LIMIT + 1);

  logic [TW-1:0] count;

  // Cycle counter, cleared whenever no request is outstanding
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + TW'(1);
    end
  end

  // High during the LIMIT-th request cycle, so the abort edge ends exactly LIMIT cycles
  assign expired_c = (count == TW'(LIMIT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// Memory access stage: one word transaction per ALU command over a req/ack bus.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned         TIMEOUT_CYCLES = 255,
  parameter logic [WORD_W-1:0]   ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        MemIO,
  input  logic [WORD_W-1:0] ALUAddr,
  inout  wire  [WORD_W-1:0] DataIO,
  output logic              ValidMemData,
  output logic              MemError,
  output logic              MemBusy,
  output logic              BusReq,
  output logic              BusWe,
  output logic [WORD_W-1:0] BusAddr,
  output logic [WORD_W-1:0] BusWData,
  input  logic [WORD_W-1:0] BusRData,
  input  logic              BusAck
);

  state_t            state;
  memio_t            cmd_q;
  logic [WORD_W-1:0] rdata_q;
  logic              drive_en;
  logic              expired_c;

  mem_req_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr       (state != ST_REQ),
    .en        (state == ST_REQ),
    .expired_c (expired_c)
  );

  // Read data is only ever placed on the ALU bus during the completion cycle
  assign DataIO = drive_en ? rdata_q : {WORD_W{1'bz}};

  // Transaction FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cmd_q        <= MEMIO_NONE;
      rdata_q      <= '0;
      drive_en     <= 1'b0;
      ValidMemData <= 1'b0;
      MemError     <= 1'b0;
      MemBusy      <= 1'b0;
      BusReq       <= 1'b0;
      BusWe        <= 1'b0;
      BusAddr      <= '0;
      BusWData     <= '0;
    end else begin
      ValidMemData <= 1'b0;
      MemError     <= 1'b0;
      drive_en     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (MemIO != MEMIO_NONE) begin
            cmd_q   <= memio_t'(MemIO);
            BusAddr <= ALUAddr;
            MemBusy <= 1'b1;
            if (MemIO == MEMIO_WRITE) begin
              BusWData <= DataIO;
            end
            if (MemIO == MEMIO_ILLEGAL || ALUAddr[1:0] != 2'b00) begin
              // Rejected without touching the bus
              state        <= ST_DONE;
              ValidMemData <= 1'b1;
              MemError     <= 1'b1;
              rdata_q      <= ERR_RDATA;
              drive_en     <= (MemIO == MEMIO_READ);
            end else begin
              state  <= ST_REQ;
              BusReq <= 1'b1;
              BusWe  <= (MemIO == MEMIO_WRITE);
            end
          end
        end
        ST_REQ: begin
          if (BusAck || expired_c) begin
            state        <= ST_DONE;
            BusReq       <= 1'b0;
            BusWe        <= 1'b0;
            ValidMemData <= 1'b1;
            MemError     <= !BusAck;
            rdata_q      <= BusAck ? BusRData : ERR_RDATA;
            drive_en     <= (cmd_q == MEMIO_READ);
          end
        end
        ST_DONE: begin
          state <= ST_RELEASE;
        end
        ST_RELEASE: begin
          // Hold off until the ALU drops its command so it is not reissued
          if (MemIO == MEMIO_NONE) begin
            state   <= ST_IDLE;
            MemBusy <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory access stage directly downstream of the ALU. Accepts the ALU's memory command (MemIO, ALUAddr, write data on DataIO) and runs one word transaction on the data-memory bus with a req/ack handshake. Returns read data on DataIO and pulses ValidMemData to release the ALU. Enforces word alignment and a bounded wait, so a dead bus cannot stall the CPU.

## Interface
- TIMEOUT_CYCLES, 255: maximum BusReq cycles without BusAck before abort; legal range 1..65535.
- ERR_RDATA, 32'h0000_0000: value returned on DataIO for an aborted or illegal read.
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- MemIO  in  2  ALU command: 00 none, 01 read, 10 write, 11 illegal. Held by the ALU until ValidMemData.
- ALUAddr  in  32  byte address; must be word aligned.
- DataIO  inout  32  ALU side. Write data is sampled from it. Read data is driven onto it only during the ValidMemData cycle of a read; otherwise high-Z.
- ValidMemData  out  1  one-cycle completion pulse to the ALU.
- MemError  out  1  high together with ValidMemData when the transaction failed.
- MemBusy  out  1  high in every state except IDLE.
- BusReq  out  1  bus request, held until ack or abort.
- BusWe  out  1  1 = write; valid while BusReq.
- BusAddr  out  32  word-aligned address; valid while BusReq.
- BusWData  out  32  write data; valid while BusReq && BusWe.
- BusRData  in  32  read data; sampled in the BusAck cycle.
- BusAck  in  1  slave completion, one cycle, sampled only while BusReq.

## Operation
- States: IDLE, REQ, DONE, RELEASE.
- IDLE: if MemIO≠00, latch ALUAddr, DataIO and the command.
  - Legal, aligned command -> REQ.
  - MemIO=11 or ALUAddr[1:0]≠00 -> DONE with the error flag set. No bus cycle is issued.
- REQ: BusReq=1, BusWe=(cmd==10), BusAddr and BusWData come from the latches. The timer increments each cycle.
  - BusAck=1 -> capture BusRData, go to DONE (no error).
  - Timer reaches TIMEOUT_CYCLES with no ack -> DONE with error; rdata = ERR_RDATA.
- DONE, exactly one cycle:
  - ValidMemData=1 and MemError=error flag.
  - Read command: DataIO driven with the captured data. Write command: DataIO stays high-Z.
  - Next state is RELEASE.
- RELEASE: wait for MemIO=00, then go to IDLE. This prevents a held command from being issued twice. MemIO=00 seen in DONE still passes through RELEASE for one cycle.
- BusAck outside REQ is ignored. A late ack after a timeout is discarded.
- Reset values: state IDLE; ValidMemData, MemError, MemBusy, BusReq, BusWe = 0; BusAddr, BusWData, rdata latches = 0; DataIO high-Z; timer 0.
- Reset in any state, including mid-REQ: BusReq drops at that edge and nothing completes. The slave must tolerate an abandoned request.

## Timing
- Edge E0 samples MemIO≠00 in IDLE. BusReq is high after E0.
- BusAck high at edge E0+k (k≥1) -> ValidMemData high for the cycle after E0+k.
  - Minimum latency is 2 cycles from the first sampled command.
  - BusReq is low in that same cycle.
- Timeout: BusReq is high for exactly TIMEOUT_CYCLES cycles, then ValidMemData=MemError=1 for one cycle.
- Illegal or misaligned command: ValidMemData=MemError=1 in the cycle after E0. BusReq never asserts.
- Next acceptance is at the earliest 2 cycles after ValidMemData (DONE, then RELEASE, then IDLE), given MemIO=00.
- All outputs are registered. The DataIO enable is registered and asserts only in DONE.

## Structure
- Shared package (the CPU-wide definitions package): MemIO encodings (MEMIO_NONE/READ/WRITE/ILLEGAL), the state enum, and the default ERR_RDATA.
- One sub-module, mem_req_timer: clear/enable counter of width $clog2(TIMEOUT_CYCLES+1) with an expired output. Everything else stays in mem_access_unit.

## Test plan
- Read, ack after 3 cycles: MemIO=01, ALUAddr=0x100, BusRData=0x1234_5678 -> BusReq for 3 cycles with BusAddr=0x100, BusWe=0; then ValidMemData=1, MemError=0, DataIO=0x1234_5678 for one cycle.
- Write, immediate ack: MemIO=10, ALUAddr=0x40, DataIO=0xCAFE_0001 -> BusWe=1, BusWData=0xCAFE_0001, ValidMemData exactly 2 cycles after the command, DataIO never driven.
- Timeout: TIMEOUT_CYCLES=4, read, BusAck held at 0 -> BusReq high exactly 4 cycles, then ValidMemData=MemError=1 with DataIO=ERR_RDATA. A late BusAck has no effect.
- Illegal commands: MemIO=11, and separately read at ALUAddr=0x102 -> BusReq stays 0, ValidMemData=MemError=1 the next cycle.
- Held command: MemIO=01 held for 10 cycles after completion -> exactly one BusReq burst and one ValidMemData pulse. After MemIO=00 for one cycle and a new read, a second transaction starts.
- Reset mid-REQ: rst=1 on the second BusReq cycle -> BusReq=0 and all outputs at reset values after that edge, no ValidMemData. The following read completes normally.
